// File: rtl/branch_redirect_unit_pkg.sv
// Shared opcodes, FSM encoding and reset PC
// for the branch redirect unit.
package branch_redirect_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Decodes beq/bne/j/jal/jr and computes
// whether the transfer is taken and where to.
module branch_target_calc
  import branch_redirect_unit_pkg::*;
(
  input  logic [31:0] instruct,
  input  logic [31:0] PCAddr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        is_xfer,
  output logic        taken,
  output logic [31:0] target
);

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [31:0] w_pc4;
  logic [31:0] w_boff;
  logic        w_beq;
  logic        w_bne;
  logic        w_jmp;
  logic        w_jr;

  assign w_op   = instruct[31:26];
  assign w_fn   = instruct[5:0];
  assign w_pc4  = PCAddr + 32'd4;
  assign w_boff = {{14{instruct[15]}},
                   instruct[15:0], 2'b00};

  assign w_beq = (w_op == OP_BEQ);
  assign w_bne = (w_op == OP_BNE);
  assign w_jmp = (w_op == OP_J) ||
                 (w_op == OP_JAL);
  assign w_jr  = (w_op == OP_SPECIAL) &&
                 (w_fn == FN_JR);

  assign is_xfer = w_beq | w_bne |
                   w_jmp | w_jr;

  always_comb begin
    taken  = 1'b0;
    target = '0;
    unique case (1'b1)
      w_beq: begin
        taken  = (rs_data == rt_data);
        target = w_pc4 + w_boff;
      end
      w_bne: begin
        taken  = (rs_data != rt_data);
        target = w_pc4 + w_boff;
      end
      w_jmp: begin
        taken  = 1'b1;
        target = {w_pc4[31:28],
                  instruct[25:0], 2'b00};
      end
      w_jr: begin
        taken  = 1'b1;
        target = rs_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Next-PC control for fetch with an optional
// MIPS delay slot and a saturating redirect count.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruct,
  input  logic [31:0]      PCAddr,
  output logic [4:0]       RsAddr,
  output logic [4:0]       RtAddr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             jump_flag,
  output logic [31:0]      JumpOffset,
  output logic             LinkWrite,
  output logic [31:0]      LinkAddr,
  output logic [CNT_W-1:0] RedirectCount
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [31:0]      r_pend_tgt;
  logic [CNT_W-1:0] r_cnt;

  logic        w_is_xfer;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_fire;
  logic        w_capture;
  logic        w_jf;
  logic [31:0] w_off;

  branch_target_calc u_calc (
    .instruct (instruct),
    .PCAddr   (PCAddr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .is_xfer  (w_is_xfer),
    .taken    (w_taken),
    .target   (w_target)
  );

  assign w_fire = w_is_xfer & w_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pend_tgt <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture)
        r_pend_tgt <= w_target;
      if (jump_flag && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Transfers decoded in SLOT are the delay
  // slot itself and are deliberately dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_jf        = 1'b0;
    w_off       = '0;
    if (DELAY_SLOT != 0) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            w_state_nxt = ST_SLOT;
            w_capture   = 1'b1;
          end
        end
        ST_SLOT: begin
          w_state_nxt = ST_IDLE;
          w_jf        = 1'b1;
          w_off       = r_pend_tgt;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = ST_IDLE;
      w_jf        = w_fire;
      w_off       = w_target;
    end
  end

  assign jump_flag  = w_jf & ~reset;
  assign JumpOffset = jump_flag ? w_off : '0;

  assign RsAddr    = instruct[25:21];
  assign RtAddr    = instruct[20:16];
  assign LinkWrite = (instruct[31:26] == OP_JAL);
  assign LinkAddr  = PCAddr + 32'd8;

  assign RedirectCount = r_cnt;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench: driver queues expectations,
// a negedge monitor pops and compares them.
module tb_branch_redirect_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruct;
  logic [31:0] PCAddr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic [4:0]  rsa1, rta1, rsa0, rta0, rsa2, rta2;
  logic        jf1, jf0, jf2;
  logic [31:0] off1, off0, off2;
  logic        lw1, lw0, lw2;
  logic [31:0] la1, la0, la2;
  logic [31:0] cnt1, cnt0;
  logic [1:0]  cnt2;

  branch_redirect_unit #(
    .DELAY_SLOT(1), .CNT_W(32)
  ) u_ds1 (
    .clk(clk), .reset(reset),
    .instruct(instruct), .PCAddr(PCAddr),
    .RsAddr(rsa1), .RtAddr(rta1),
    .rs_data(rs_data), .rt_data(rt_data),
    .jump_flag(jf1), .JumpOffset(off1),
    .LinkWrite(lw1), .LinkAddr(la1),
    .RedirectCount(cnt1)
  );

  branch_redirect_unit #(
    .DELAY_SLOT(0), .CNT_W(32)
  ) u_ds0 (
    .clk(clk), .reset(reset),
    .instruct(instruct), .PCAddr(PCAddr),
    .RsAddr(rsa0), .RtAddr(rta0),
    .rs_data(rs_data), .rt_data(rt_data),
    .jump_flag(jf0), .JumpOffset(off0),
    .LinkWrite(lw0), .LinkAddr(la0),
    .RedirectCount(cnt0)
  );

  branch_redirect_unit #(
    .DELAY_SLOT(1), .CNT_W(2)
  ) u_sat (
    .clk(clk), .reset(reset),
    .instruct(instruct), .PCAddr(PCAddr),
    .RsAddr(rsa2), .RtAddr(rta2),
    .rs_data(rs_data), .rt_data(rt_data),
    .jump_flag(jf2), .JumpOffset(off2),
    .LinkWrite(lw2), .LinkAddr(la2),
    .RedirectCount(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ckc;
    logic        jf;
    logic [31:0] off;
    logic [31:0] cnt;
    logic [1:0]  cnt2;
    logic        jf0;
    logic [31:0] off0;
    logic        lw;
    logic [31:0] la;
    logic [4:0]  rsa;
    logic [4:0]  rta;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string n,
                     input string f,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s.%s: got %h, want %h",
               n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "jump_flag", 32'(jf1), 32'(e.jf));
      chk(e.name, "JumpOffset", off1, e.off);
      chk(e.name, "ds0_jump_flag",
          32'(jf0), 32'(e.jf0));
      chk(e.name, "ds0_JumpOffset", off0, e.off0);
      chk(e.name, "LinkWrite", 32'(lw1), 32'(e.lw));
      chk(e.name, "LinkAddr", la1, e.la);
      chk(e.name, "RsAddr", 32'(rsa1), 32'(e.rsa));
      chk(e.name, "RtAddr", 32'(rta1), 32'(e.rta));
      if (e.ckc) begin
        chk(e.name, "RedirectCount", cnt1, e.cnt);
        chk(e.name, "sat_count",
            32'(cnt2), 32'(e.cnt2));
      end
    end
  end

  task automatic step(input string n,
                      input logic [31:0] ins,
                      input logic [31:0] pc,
                      input logic [31:0] rs,
                      input logic [31:0] rt,
                      input logic rst,
                      input logic ckc,
                      input logic jf,
                      input logic [31:0] off,
                      input logic [31:0] cnt,
                      input logic jfz,
                      input logic [31:0] offz);
    exp_t e;
    instruct = ins;
    PCAddr   = pc;
    rs_data  = rs;
    rt_data  = rt;
    reset    = rst;
    e.name = n;
    e.ckc  = ckc;
    e.jf   = jf;
    e.off  = off;
    e.cnt  = cnt;
    e.cnt2 = (cnt > 32'd3) ? 2'd3 : cnt[1:0];
    e.jf0  = jfz;
    e.off0 = offz;
    e.lw   = (ins[31:26] == 6'b000011);
    e.la   = pc + 32'd8;
    e.rsa  = ins[25:21];
    e.rta  = ins[20:16];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] BEQ3 = 32'h1022_0003;
  localparam logic [31:0] BNE5 = 32'h1422_0005;
  localparam logic [31:0] BEQM = 32'h1022_FFFF;
  localparam logic [31:0] JAL  = 32'h0C00_0C03;
  localparam logic [31:0] JR1  = 32'h0020_0008;
  localparam logic [31:0] J34  = 32'h0800_0D00;

  initial begin
    int w;
    reset    = 1'b1;
    instruct = NOP;
    PCAddr   = 32'h3000;
    rs_data  = '0;
    rt_data  = '0;
    @(posedge clk);
    #1;
    step("rst0", NOP, 32'h3000, 0, 0, 1,
         0, 0, 0, 0, 0, 0);
    step("rst1", NOP, 32'h3000, 0, 0, 1,
         1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("idle", NOP, 32'h3000, 0, 0, 0,
           1, 0, 0, 0, 0, 0);
    step("beq", BEQ3, 32'h3008, 5, 5, 0,
         1, 0, 0, 0, 1, 32'h3018);
    step("beq_slot", NOP, 32'h300C, 5, 5, 0,
         1, 1, 32'h3018, 0, 0, 0);
    step("beq_done", NOP, 32'h3018, 5, 5, 0,
         1, 0, 0, 1, 0, 0);
    step("bne", BNE5, 32'h301C, 7, 7, 0,
         1, 0, 0, 1, 0, 0);
    step("bne_next", NOP, 32'h3020, 7, 7, 0,
         1, 0, 0, 1, 0, 0);
    step("beq_back", BEQM, 32'h3010, 5, 5, 0,
         1, 0, 0, 1, 1, 32'h3010);
    step("back_slot", NOP, 32'h3014, 5, 5, 0,
         1, 1, 32'h3010, 1, 0, 0);
    step("back_done", NOP, 32'h3010, 0, 0, 0,
         1, 0, 0, 2, 0, 0);
    step("jal", JAL, 32'h3004, 0, 0, 0,
         1, 0, 0, 2, 1, 32'h300C);
    step("jal_slot", NOP, 32'h3008, 0, 0, 0,
         1, 1, 32'h300C, 2, 0, 0);
    step("jal_done", NOP, 32'h300C, 0, 0, 0,
         1, 0, 0, 3, 0, 0);
    step("jr", JR1, 32'h3100, 32'h3020, 0, 0,
         1, 0, 0, 3, 1, 32'h3020);
    step("jr_slot_j", J34, 32'h3104, 32'h3020, 0,
         0, 1, 1, 32'h3020, 3, 1, 32'h3400);
    step("jr_done", NOP, 32'h3020, 0, 0, 0,
         1, 0, 0, 4, 0, 0);
    step("j_ignored", NOP, 32'h3024, 0, 0, 0,
         1, 0, 0, 4, 0, 0);
    step("j_take", J34, 32'h3028, 0, 0, 0,
         1, 0, 0, 4, 1, 32'h3400);
    step("rst_slot", NOP, 32'h302C, 0, 0, 1,
         1, 0, 0, 4, 0, 0);
    step("rst_rel", NOP, 32'h3030, 0, 0, 0,
         1, 0, 0, 0, 0, 0);
    step("rst_quiet", NOP, 32'h3034, 0, 0, 0,
         1, 0, 0, 0, 0, 0);
    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: left %0d, want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
